// File: rtl/spi_arbiter_seq.sv
// Two-port transaction sequencer in front of SPIMaster.
// Grants the SPIMaster to r0 or r1 for a whole multi-byte transaction, drives
// the active-low slave selects with setup/hold/gap timing, and aborts a byte
// whose completion never arrives within TIMEOUT cycles.
module spi_arbiter_seq #(
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int IDLE_GAP = 1,
   parameter int TIMEOUT  = 1023
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       r0_req,
   input  logic       r1_req,
   input  logic [1:0] r0_cs,
   input  logic [1:0] r1_cs,
   input  logic [3:0] r0_len,
   input  logic [3:0] r1_len,
   input  logic [7:0] r0_tx,
   input  logic [7:0] r1_tx,
   output logic       r0_tx_ack,
   output logic       r1_tx_ack,
   output logic [7:0] r0_rx,
   output logic [7:0] r1_rx,
   output logic       r0_rx_valid,
   output logic       r1_rx_valid,
   output logic       r0_grant,
   output logic       r1_grant,
   output logic       r0_done,
   output logic       r1_done,
   output logic       r0_err,
   output logic       r1_err,
   output logic       spi_start,
   output logic [0:7] spi_data_in,
   input  logic       spi_busy,
   input  logic       spi_new_data,
   input  logic [0:7] spi_data_out,
   output logic [3:0] ss_n
);

   localparam int SH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int PH_MAX = (SH_MAX > IDLE_GAP) ? SH_MAX : IDLE_GAP;
   localparam int PW     = $clog2(PH_MAX + 1);
   localparam int TW     = $clog2(TIMEOUT + 1);

   localparam logic [PW-1:0] SETUP_LAST = PW'(CS_SETUP - 1);
   localparam logic [PW-1:0] HOLD_LAST  = PW'(CS_HOLD - 1);
   localparam logic [PW-1:0] GAP_LAST   = PW'(IDLE_GAP - 1);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_SETUP,
      S_LOAD,
      S_WAIT,
      S_HOLD,
      S_GAP
   } state_t;

   state_t        state;
   logic          owner;       // 0 = r0, 1 = r1
   logic          last_owner;  // port granted most recently
   logic [1:0]    cs_q;
   logic [3:0]    byte_cnt;    // bytes remaining minus one
   logic [PW-1:0] phase;       // shared SETUP/HOLD/GAP cycle counter
   logic [TW-1:0] timer;
   logic          abort;
   logic          pick;
   logic          load_fire;

   // Round-robin choice and the byte handshake that must fire in the cycle busy drops.
   always_comb begin
      pick        = r1_req && (!r0_req || !last_owner);
      load_fire   = (state == S_LOAD) && !spi_busy;
      spi_start   = load_fire;
      r0_tx_ack   = load_fire && !owner;
      r1_tx_ack   = load_fire && owner;
      spi_data_in = owner ? r1_tx : r0_tx;
   end

   // Transaction sequencer: arbitration, slave-select timing, byte loop and timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         owner       <= 1'b0;
         last_owner  <= 1'b1;
         cs_q        <= '0;
         byte_cnt    <= '0;
         phase       <= '0;
         timer       <= '0;
         abort       <= 1'b0;
         ss_n        <= '1;
         r0_grant    <= 1'b0;
         r1_grant    <= 1'b0;
         r0_rx       <= '0;
         r1_rx       <= '0;
         r0_rx_valid <= 1'b0;
         r1_rx_valid <= 1'b0;
         r0_done     <= 1'b0;
         r1_done     <= 1'b0;
         r0_err      <= 1'b0;
         r1_err      <= 1'b0;
      end else begin
         r0_rx_valid <= 1'b0;
         r1_rx_valid <= 1'b0;
         r0_done     <= 1'b0;
         r1_done     <= 1'b0;
         r0_err      <= 1'b0;
         r1_err      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (r0_req || r1_req) state <= S_ARB;
            end
            S_ARB: begin
               if (r0_req || r1_req) begin
                  owner    <= pick;
                  cs_q     <= pick ? r1_cs : r0_cs;
                  byte_cnt <= pick ? r1_len : r0_len;
                  r0_grant <= !pick;
                  r1_grant <= pick;
                  ss_n     <= ~(4'b0001 << (pick ? r1_cs : r0_cs));
                  phase    <= '0;
                  abort    <= 1'b0;
                  state    <= S_SETUP;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_SETUP: begin
               if (phase == SETUP_LAST) begin
                  phase <= '0;
                  state <= S_LOAD;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            S_LOAD: begin
               if (!spi_busy) begin
                  timer <= '0;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (spi_new_data) begin
                  if (owner) begin
                     r1_rx       <= spi_data_out;
                     r1_rx_valid <= 1'b1;
                  end else begin
                     r0_rx       <= spi_data_out;
                     r0_rx_valid <= 1'b1;
                  end
                  if (byte_cnt == 4'd0) begin
                     phase <= '0;
                     state <= S_HOLD;
                  end else begin
                     byte_cnt <= byte_cnt - 1'b1;
                     state    <= S_LOAD;
                  end
               end else if (timer == TO_LAST) begin
                  abort <= 1'b1;
                  phase <= '0;
                  state <= S_HOLD;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_HOLD: begin
               if (phase == HOLD_LAST) begin
                  ss_n    <= '1;
                  r0_done <= !owner;
                  r1_done <= owner;
                  r0_err  <= !owner && abort;
                  r1_err  <= owner && abort;
                  phase   <= '0;
                  state   <= S_GAP;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            S_GAP: begin
               if (phase == GAP_LAST) begin
                  r0_grant   <= 1'b0;
                  r1_grant   <= 1'b0;
                  last_owner <= owner;
                  phase      <= '0;
                  state      <= S_IDLE;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arbiter_seq.sv
// Randomized bench for spi_arbiter_seq with a transaction-level reference model
// and a behavioural SPIMaster stand-in (busy latency, echo data, hang, stall).
module tb_spi_arbiter_seq;

   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int IDLE_GAP = 1;
   localparam int TIMEOUT  = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic       r0_req, r1_req;
   logic [1:0] r0_cs, r1_cs;
   logic [3:0] r0_len, r1_len;
   logic [7:0] r0_tx, r1_tx;
   logic       r0_tx_ack, r1_tx_ack;
   logic [7:0] r0_rx, r1_rx;
   logic       r0_rx_valid, r1_rx_valid;
   logic       r0_grant, r1_grant;
   logic       r0_done, r1_done;
   logic       r0_err, r1_err;
   logic       spi_start;
   logic [0:7] spi_data_in;
   logic       spi_busy;
   logic       spi_new_data;
   logic [0:7] spi_data_out;
   logic [3:0] ss_n;

   spi_arbiter_seq #(
      .CS_SETUP(CS_SETUP),
      .CS_HOLD (CS_HOLD),
      .IDLE_GAP(IDLE_GAP),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req), .r1_req(r1_req),
      .r0_cs(r0_cs), .r1_cs(r1_cs),
      .r0_len(r0_len), .r1_len(r1_len),
      .r0_tx(r0_tx), .r1_tx(r1_tx),
      .r0_tx_ack(r0_tx_ack), .r1_tx_ack(r1_tx_ack),
      .r0_rx(r0_rx), .r1_rx(r1_rx),
      .r0_rx_valid(r0_rx_valid), .r1_rx_valid(r1_rx_valid),
      .r0_grant(r0_grant), .r1_grant(r1_grant),
      .r0_done(r0_done), .r1_done(r1_done),
      .r0_err(r0_err), .r1_err(r1_err),
      .spi_start(spi_start), .spi_data_in(spi_data_in),
      .spi_busy(spi_busy), .spi_new_data(spi_new_data),
      .spi_data_out(spi_data_out), .ss_n(ss_n)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // requester configuration for each port's next transaction
   int         n_pend [2];
   logic [1:0] cs_cfg [2];
   logic [3:0] len_cfg[2];
   logic [7:0] tx_bytes[2][16];
   int         tx_idx [2];
   int         hang_cfg[2];
   bit         drop_cfg[2];
   bit         stall_cfg[2];
   bit         faults;
   bit         spurious_en;
   bit         echo_only;
   int         lat_fixed;

   // reference model of the transaction in progress
   bit         active, post, in_hold, gap_valid, rxv_due, start_asap;
   bit         owner, last;
   logic [1:0] cur_cs;
   int         cur_len, starts, nd_cnt, setup_cnt, hold_cnt, exp_hold;
   int         hang_idx, post_cnt, ss_gap;
   bit         drop_cur, stall_cur;
   logic [1:0] prev_req;
   logic [7:0] exp_q[$];
   int         grant_log[$];

   // SPIMaster stand-in
   bit         m_inflight, m_hang, nd_legit;
   int         m_lat, m_stall;
   logic [7:0] m_byte, m_mask, m_ret;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] dec(input logic [0:7] v);
      logic [7:0] d;
      for (int i = 0; i < 8; i++) d[7-i] = v[i];
      return d;
   endfunction

   function automatic logic [0:7] enc(input logic [7:0] b);
      logic [0:7] e;
      for (int i = 0; i < 8; i++) e[i] = b[7-i];
      return e;
   endfunction

   task automatic regen(input int p);
      int r;
      cs_cfg[p] = 2'($urandom_range(3));
      r = $urandom_range(9);
      len_cfg[p] = (r == 0) ? 4'd15 : 4'($urandom_range(4));
      for (int i = 0; i < 16; i++) tx_bytes[p][i] = 8'($urandom);
      tx_idx[p] = 0;
      if (faults) begin
         hang_cfg[p]  = ($urandom_range(4) == 0) ? int'($urandom_range(int'(len_cfg[p]))) : -1;
         drop_cfg[p]  = 1'($urandom_range(1));
         stall_cfg[p] = ($urandom_range(3) == 0);
      end else begin
         hang_cfg[p]  = -1;
         drop_cfg[p]  = 1'b0;
         stall_cfg[p] = 1'b0;
      end
   endtask

   task automatic drive();
      int i0, i1;
      nd_legit     = 1'b0;
      spi_new_data = 1'b0;
      spi_busy     = 1'b0;
      if (m_hang) begin
         spi_busy = 1'b1;
      end else if (m_inflight) begin
         if (m_lat > 0) begin
            spi_busy = 1'b1;
            m_lat--;
         end else begin
            m_ret        = m_byte ^ m_mask;
            spi_new_data = 1'b1;
            spi_data_out = enc(m_ret);
            m_inflight   = 1'b0;
            nd_legit     = 1'b1;
            nd_cnt++;
            if (nd_cnt < cur_len + 1 && stall_cur) m_stall = 10;
         end
      end else if (m_stall > 0) begin
         spi_busy = 1'b1;
         m_stall--;
      end else if (spurious_en && $urandom_range(7) == 0) begin
         spi_new_data = 1'b1;
         spi_data_out = enc(8'($urandom));
      end
      r0_req = (n_pend[0] > 0) && !(active && !owner && drop_cur);
      r1_req = (n_pend[1] > 0) && !(active && owner && drop_cur);
      r0_cs  = cs_cfg[0];
      r1_cs  = cs_cfg[1];
      r0_len = len_cfg[0];
      r1_len = len_cfg[1];
      i0 = (tx_idx[0] > 15) ? 15 : tx_idx[0];
      i1 = (tx_idx[1] > 15) ? 15 : tx_idx[1];
      r0_tx  = tx_bytes[0][i0];
      r1_tx  = tx_bytes[1][i1];
   endtask

   task automatic sample();
      logic [3:0] exp_ss;
      logic [1:0] own_bits;
      bit         done_seen;
      int         ti;
      done_seen = 1'b0;
      own_bits  = owner ? 2'b10 : 2'b01;
      chk("grant_onehot", r0_grant & r1_grant, 0);

      if (post) begin
         if (r0_grant || r1_grant) begin
            post_cnt++;
            chk("gap_ss_high", ss_n, 4'hF);
         end else begin
            chk("gap_grant_cycles", post_cnt, IDLE_GAP);
            post = 1'b0;
         end
      end

      if (!active) begin
         if (ss_n == 4'hF) ss_gap++;
         if (!post && (r0_grant || r1_grant)) begin
            owner = r1_grant;
            chk("grant_owner", owner, (prev_req == 2'b11) ? !last : prev_req[1]);
            if (gap_valid) chk("ss_gap_min", ss_gap >= IDLE_GAP, 1);
            grant_log.push_back(int'(owner));
            active     = 1'b1;
            cur_cs     = cs_cfg[owner];
            cur_len    = int'(len_cfg[owner]);
            hang_idx   = hang_cfg[owner];
            drop_cur   = drop_cfg[owner];
            stall_cur  = stall_cfg[owner];
            starts     = 0;
            nd_cnt     = 0;
            setup_cnt  = 0;
            in_hold    = 1'b0;
            start_asap = 1'b0;
            exp_q.delete();
            own_bits   = owner ? 2'b10 : 2'b01;
         end else begin
            chk("ss_idle", ss_n, 4'hF);
         end
      end

      if (active) begin
         exp_ss = ~(4'b0001 << cur_cs);
         if (in_hold && ss_n == 4'hF) begin
            done_seen = 1'b1;
            chk("hold_cycles", hold_cnt, exp_hold);
            chk("done", {r1_done, r0_done}, own_bits);
            chk("err", {r1_err, r0_err}, (hang_idx >= 0) ? own_bits : 2'b00);
            chk("byte_count", starts, (hang_idx >= 0) ? hang_idx + 1 : cur_len + 1);
            m_hang = 1'b0;
            n_pend[owner]--;
            last = owner;
            regen(int'(owner));
            active    = 1'b0;
            post      = 1'b1;
            post_cnt  = 1;
            ss_gap    = 1;
            gap_valid = 1'b1;
         end else begin
            chk("ss_sel", ss_n, exp_ss);
            if (in_hold) hold_cnt++;
            if (starts == 0 && !spi_start) setup_cnt++;
         end
      end

      if (spi_start) begin
         chk("start_busy", spi_busy, 0);
         chk("start_in_txn", active && !in_hold, 1);
         chk("tx_ack", {r1_tx_ack, r0_tx_ack}, own_bits);
         ti = (starts > 15) ? 15 : starts;
         chk("tx_byte", dec(spi_data_in), tx_bytes[owner][ti]);
         if (starts == 0) chk("setup_cycles", setup_cnt, CS_SETUP);
         if (starts == hang_idx) begin
            m_hang   = 1'b1;
            in_hold  = 1'b1;
            hold_cnt = 0;
            exp_hold = TIMEOUT + CS_HOLD;
         end else begin
            m_inflight = 1'b1;
            m_byte     = dec(spi_data_in);
            m_mask     = echo_only ? 8'h00 : 8'($urandom);
            if (lat_fixed >= 0) m_lat = lat_fixed;
            else m_lat = ($urandom_range(5) == 0) ? 14 : int'($urandom_range(8));
         end
         tx_idx[owner]++;
         starts++;
         start_asap = 1'b0;
      end else begin
         chk("tx_ack_idle", {r1_tx_ack, r0_tx_ack}, 0);
         if (start_asap && !spi_busy) begin
            chk("start_asap", spi_start, 1);
            start_asap = 1'b0;
         end
      end

      if (nd_legit && active) begin
         exp_q.push_back(m_ret);
         if (nd_cnt == cur_len + 1) begin
            in_hold  = 1'b1;
            hold_cnt = 0;
            exp_hold = CS_HOLD;
         end else begin
            start_asap = 1'b1;
         end
      end

      chk("rx_valid", {r1_rx_valid, r0_rx_valid}, rxv_due ? own_bits : 2'b00);
      if (rxv_due && exp_q.size() > 0) chk("rx_byte", owner ? r1_rx : r0_rx, exp_q.pop_front());
      rxv_due = nd_legit;

      if (!done_seen) chk("done_idle", {r1_done, r0_done, r1_err, r0_err}, 0);
      prev_req = {r1_req, r0_req};
   endtask

   task automatic step();
      @(negedge clk);
      drive();
      #4;
      sample();
   endtask

   task automatic run_until_idle(input int budget);
      int k = 0;
      while ((n_pend[0] > 0 || n_pend[1] > 0 || active || post) && k < budget) begin
         step();
         k++;
      end
      chk("drain_budget", k < budget, 1);
      repeat (3) step();
   endtask

   task automatic clear_model();
      active = 0; post = 0; in_hold = 0; gap_valid = 0; rxv_due = 0; start_asap = 0;
      m_inflight = 0; m_hang = 0; m_stall = 0; nd_legit = 0;
      last = 1'b1; owner = 1'b0; prev_req = 2'b00;
      n_pend[0] = 0; n_pend[1] = 0;
      exp_q.delete();
   endtask

   initial begin
      int k;
      faults = 0; spurious_en = 0; echo_only = 1; lat_fixed = 3;
      clear_model();
      regen(0);
      regen(1);
      rst = 1'b0;
      r0_req = 0; r1_req = 0; r0_cs = 0; r1_cs = 0; r0_len = 0; r1_len = 0;
      r0_tx = 0; r1_tx = 0; spi_busy = 0; spi_new_data = 0; spi_data_out = '0;

      // reset state
      repeat (3) @(negedge clk);
      #4;
      chk("rst_ss_n", ss_n, 4'hF);
      chk("rst_grant", {r1_grant, r0_grant}, 0);
      chk("rst_done_err", {r1_done, r0_done, r1_err, r0_err}, 0);
      chk("rst_rx_valid", {r1_rx_valid, r0_rx_valid}, 0);
      chk("rst_start_ack", {spi_start, r1_tx_ack, r0_tx_ack}, 0);
      chk("rst_rx", {r1_rx, r0_rx}, 0);
      @(negedge clk);
      rst = 1'b1;

      // single byte, r0, slave 2
      cs_cfg[0] = 2'd2; len_cfg[0] = 4'd0; tx_bytes[0][0] = 8'hA5; tx_idx[0] = 0;
      n_pend[0] = 1;
      run_until_idle(2000);
      chk("single_rx", r0_rx, 8'hA5);

      // four bytes on r1
      cs_cfg[1] = 2'd1; len_cfg[1] = 4'd3; tx_idx[1] = 0;
      tx_bytes[1][0] = 8'h11; tx_bytes[1][1] = 8'h22; tx_bytes[1][2] = 8'h33; tx_bytes[1][3] = 8'h44;
      n_pend[1] = 1;
      run_until_idle(2000);
      chk("multi_last_rx", r1_rx, 8'h44);

      // contention: both rise together, alternate
      grant_log.delete();
      lat_fixed = -1;
      n_pend[0] = 2; n_pend[1] = 2;
      run_until_idle(4000);
      chk("contend_n", grant_log.size(), 4);
      if (grant_log.size() >= 3) begin
         chk("contend_1st", grant_log[0], 0);
         chk("contend_2nd", grant_log[1], 1);
         chk("contend_3rd", grant_log[2], 0);
      end

      // timeout on r0 byte 1 of 3, r1 served afterwards
      regen(0); regen(1);
      len_cfg[0] = 4'd2; hang_cfg[0] = 1;
      n_pend[0] = 1; n_pend[1] = 1;
      run_until_idle(4000);

      // busy stall between bytes on r1
      regen(1);
      len_cfg[1] = 4'd2; stall_cfg[1] = 1'b1; lat_fixed = 2;
      n_pend[1] = 1;
      run_until_idle(2000);

      // randomized traffic with hangs, stalls, dropped requests and stray new_data
      faults = 1; spurious_en = 1; echo_only = 0; lat_fixed = -1;
      regen(0); regen(1);
      for (int b = 0; b < 12; b++) begin
         n_pend[0] = int'($urandom_range(2));
         n_pend[1] = int'($urandom_range(2));
         if (n_pend[0] == 0 && n_pend[1] == 0) n_pend[0] = 1;
         run_until_idle(8000);
      end

      // reset during byte 2 of 4: r0 last, r1 interrupted, then both request
      faults = 0; spurious_en = 0; echo_only = 1; lat_fixed = 3;
      regen(0); regen(1);
      n_pend[0] = 1;
      run_until_idle(2000);
      len_cfg[1] = 4'd3; lat_fixed = 6; n_pend[1] = 1;
      k = 0;
      while (!(active && owner && starts >= 2) && k < 2000) begin
         step();
         k++;
      end
      chk("reach_byte2", k < 2000, 1);
      step();
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_ss_n", ss_n, 4'hF);
      chk("mid_rst_grant", {r1_grant, r0_grant}, 0);
      r0_req = 0; r1_req = 0; spi_busy = 0; spi_new_data = 0;
      clear_model();
      regen(0); regen(1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      grant_log.delete();
      n_pend[0] = 1; n_pend[1] = 1;
      run_until_idle(3000);
      chk("post_rst_n", grant_log.size(), 2);
      if (grant_log.size() >= 2) begin
         chk("post_rst_1st", grant_log[0], 0);
         chk("post_rst_2nd", grant_log[1], 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_arbiter_seq.md
Name: spi_arbiter_seq

Overview:
- Transaction sequencer and two-port arbiter in front of SPIMaster in the 8051 logic.
- Grants the single SPIMaster to one of two requesters (8051 port bridge = r0, auxiliary engine = r1) per multi-byte transaction.
- Drives active-low slave selects with setup/hold timing and feeds/collects bytes through SPIMaster's start/busy/new_data handshake.
- Adds a per-byte timeout so a hung transfer cannot lock the bus.

Parameters:
- CS_SETUP, 2, clk cycles between ss_n assertion and first spi_start (min 1)
- CS_HOLD, 2, clk cycles between last new_data and ss_n deassertion (min 1)
- IDLE_GAP, 1, clk cycles all ss_n high before next grant (min 1)
- TIMEOUT, 1023, max clk cycles from spi_start to spi_new_data before abort

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- r0_req / r1_req  in  1  level; high requests a transaction, sampled only in ARB
- r0_cs / r1_cs  in  2  target slave index 0..3, latched at grant
- r0_len / r1_len  in  4  byte count minus 1 (0 = 1 byte, 15 = 16 bytes), latched at grant
- r0_tx / r1_tx  in  8  current transmit byte; bit 7 sent first
- r0_tx_ack / r1_tx_ack  out  1  1-cycle pulse when r*_tx is consumed; requester presents the next byte by the following cycle
- r0_rx / r1_rx  out  8  received byte, valid with rx_valid, held until next rx_valid
- r0_rx_valid / r1_rx_valid  out  1  1-cycle pulse per received byte
- r0_grant / r1_grant  out  1  level, high from grant until end of IDLE_GAP; one-hot or zero
- r0_done / r1_done  out  1  1-cycle pulse at end of CS_HOLD
- r0_err / r1_err  out  1  1-cycle pulse coincident with done when the transaction aborted on timeout
- spi_start  out  1  1-cycle start pulse to SPIMaster
- spi_data_in  out  8 ([0:7])  byte to SPIMaster; spi_data_in[0] = tx[7]
- spi_busy  in  1  SPIMaster busy
- spi_new_data  in  1  SPIMaster byte-complete pulse
- spi_data_out  in  8 ([0:7])  SPIMaster received byte; spi_data_out[0] = rx[7]
- ss_n  out  4  active-low slave selects, at most one low

Behaviour:
- Reset (async, rst=0): state IDLE; ss_n=4'hF; all other outputs 0; rr pointer favours r0; counters cleared. Reset mid-transfer releases ss_n immediately. SPIMaster is reset separately and is not aborted by this block.
- IDLE→ARB when any req=1.
- ARB, single request: grant it.
- ARB, both requests: grant the requester not granted last (round-robin); after reset r0 wins.
- ARB, grant cycle: latch cs and len into cnt; assert grant; drive ss_n[cs]=0 next cycle.
- SETUP: count CS_SETUP cycles, then LOAD.
- LOAD: wait while spi_busy=1. When spi_busy=0: spi_start=1 and spi_data_in=tx for 1 cycle; tx_ack pulses in the same cycle; go to WAIT with the timeout counter cleared.
- WAIT, spi_new_data=1: capture spi_data_out into rx; rx_valid pulses the next cycle. If cnt==0 go to HOLD, else decrement cnt and go to LOAD.
- WAIT, timer reaches TIMEOUT: set abort flag and go to HOLD. No rx_valid for the hung byte.
- spi_new_data outside WAIT: ignored.
- HOLD: CS_HOLD cycles, then ss_n=4'hF. done pulses (err too if aborted). Go to GAP.
- GAP: IDLE_GAP cycles with ss_n high, then drop grant, return to IDLE, update rr pointer.
- Req deasserted after grant: ignored; the latched len completes.
- Req held through done: re-arbitrated normally, so it can win again only if the other port is idle.
- Byte-to-byte spacing: ≥1 cycle in LOAD per byte. No SPI clocking in this block; sck timing belongs to SPIMaster.

Test Plan:
- Single transfer: r0_req, cs=2, len=0, tx=8'hA5, model echoes MISO.
  → ss_n=4'b1011 for CS_SETUP cycles before spi_start; one tx_ack; r0_rx=8'hA5 with r0_rx_valid; r0_done; ss_n=4'hF after CS_HOLD.
- Multi-byte transfer: r1 len=3, tx sequence 11,22,33,44.
  → 4 spi_start pulses, 4 tx_ack, 4 rx_valid in order; ss_n stays low continuously between bytes; one r1_done.
- Contention: r0_req and r1_req rise in the same cycle, both held for 3 transactions.
  → grant order r0, r1, r0; grants never overlap; ≥IDLE_GAP cycles with ss_n=4'hF between transactions.
- Timeout: model never pulses new_data, TIMEOUT=15.
  → HOLD entered at the 15th WAIT cycle; r0_done and r0_err pulse together; no rx_valid; next request still served.
- Busy stall: spi_busy forced high for 10 cycles at LOAD.
  → spi_start delayed until the cycle spi_busy=0; no duplicate start.
- Reset mid-WAIT: rst=0 during byte 2 of 4.
  → ss_n=4'hF and grants 0 asynchronously; after release, a fresh r1 request is granted with r0 priority logic reset.
